// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: flit width, header field positions and the
// packet-length tracker state encoding.
package noc_flit_pkg;

    localparam int FLIT_W     = 64;

    localparam int CHIP_ID_HI = 63;
    localparam int CHIP_ID_LO = 50;
    localparam int XPOS_HI    = 49;
    localparam int XPOS_LO    = 42;
    localparam int YPOS_HI    = 41;
    localparam int YPOS_LO    = 34;
    localparam int PLEN_HI    = 29;
    localparam int PLEN_LO    = 22;
    localparam int TYPE_HI    = 21;
    localparam int TYPE_LO    = 14;

    localparam int PLEN_W     = PLEN_HI - PLEN_LO + 1;

    // HDR: next flit is a header; PAY: payload flits still outstanding
    typedef enum logic [0:0] {
        TRK_HDR = 1'b0,
        TRK_PAY = 1'b1
    } trk_state_e;

    // Payload length (in flits, excluding the header) carried by a header flit
    function automatic logic [PLEN_W-1:0] flit_plen(input logic [FLIT_W-1:0] flit);
        return flit[PLEN_HI:PLEN_LO];
    endfunction

endpackage

// File: rtl/noc_pkt_len_tracker.sv
// Packet boundary tracker. Follows a flit stream one accepted flit at a time
// and flags whether the flit currently offered would be the last one of its
// packet. The plen input is only meaningful while the tracker is in HDR.
module noc_pkt_len_tracker
    import noc_flit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [PLEN_W-1:0] plen,
    output logic              is_last,
    output trk_state_e        state
);

    trk_state_e        state_nxt;
    logic [PLEN_W-1:0] rem;
    logic [PLEN_W-1:0] rem_nxt;

    // State and remaining-payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TRK_HDR;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Last-flit decode and next state; idle cycles hold everything
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        is_last   = 1'b0;
        case (state)
            TRK_HDR: begin
                is_last = (plen == '0);
                if (strobe && !is_last) begin
                    state_nxt = TRK_PAY;
                    rem_nxt   = plen;
                end
            end
            TRK_PAY: begin
                is_last = (rem == PLEN_W'(1));
                if (strobe) begin
                    rem_nxt = rem - PLEN_W'(1);
                    if (is_last) begin
                        state_nxt = TRK_HDR;
                    end
                end
            end
            default: begin
                state_nxt = TRK_HDR;
            end
        endcase
    end

endmodule

// File: rtl/noc_pkt_fifo_vr.sv
// Packet-aware val/rdy elastic buffer for 64-bit NoC flits.
// Optional store-and-forward build: define PKT_FIFO_STORE_FWD_EN.
//
// Handshake: a flit moves when val and rdy are both high on a rising edge.
// din_rdy depends only on registered fill state (never on dout_rdy), and
// dout_val never depends on din_val; there is no input-to-output bypass.
module noc_pkt_fifo_vr
    import noc_flit_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_W-1:0]     din_msg,
    input  logic                  din_val,
    output logic                  din_rdy,
    output logic [FLIT_W-1:0]     dout_msg,
    output logic                  dout_val,
    input  logic                  dout_rdy,
    output logic [LOG2_DEPTH:0]   occupancy,
    output logic [LOG2_DEPTH:0]   pkt_cnt,
    output logic                  err_long
);

    logic [FLIT_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  wr_last;
    logic                  rd_last;
    trk_state_e            wr_state;
    trk_state_e            rd_state;
    logic                  trk_state_unused;

    assign full     = (occupancy == (LOG2_DEPTH+1)'(DEPTH));
    assign empty    = (occupancy == '0);
    assign din_rdy  = !rst && !full;
    assign push     = din_val && din_rdy;
    assign pop      = dout_val && dout_rdy;
    assign dout_msg = mem[rd_ptr];

    // Tracker states are kept on named nets so they can be probed
    assign trk_state_unused = ^{wr_state, rd_state};

    noc_pkt_len_tracker u_wr_trk (
        .clk     (clk),
        .rst     (rst),
        .strobe  (push),
        .plen    (flit_plen(din_msg)),
        .is_last (wr_last),
        .state   (wr_state)
    );

    noc_pkt_len_tracker u_rd_trk (
        .clk     (clk),
        .rst     (rst),
        .strobe  (pop),
        .plen    (flit_plen(dout_msg)),
        .is_last (rd_last),
        .state   (rd_state)
    );

    // Flit storage; contents need no reset since occupancy gates the output
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din_msg;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**LOG2_DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            if (pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (LOG2_DEPTH+1)'(1);
                2'b01:   occupancy <= occupancy - (LOG2_DEPTH+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Count of buffered packets whose last flit has been written
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({push && wr_last, pop && rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + (LOG2_DEPTH+1)'(1);
                2'b01:   pkt_cnt <= pkt_cnt - (LOG2_DEPTH+1)'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

`ifdef PKT_FIFO_STORE_FWD_EN
    // Packets too long to ever fit are forwarded cut-through to avoid deadlock
    logic ct_mem [DEPTH];
    logic ct_pkt;
    logic wr_hdr;
    logic hdr_long;
    logic wr_ct;

    assign wr_hdr   = (wr_state == TRK_HDR);
    assign hdr_long = (int'(flit_plen(din_msg)) + 1) > DEPTH;
    assign wr_ct    = wr_hdr ? hdr_long : ct_pkt;
    assign dout_val = !empty && ((pkt_cnt != '0) || ct_mem[rd_ptr]);

    // Per-entry cut-through marks, written alongside the flit
    always_ff @(posedge clk) begin
        if (push) begin
            ct_mem[wr_ptr] <= wr_ct;
        end
    end

    // Remember the header's cut-through decision for its payload; sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            ct_pkt   <= 1'b0;
            err_long <= 1'b0;
        end else if (push && wr_hdr) begin
            ct_pkt <= hdr_long;
            if (hdr_long) begin
                err_long <= 1'b1;
            end
        end
    end
`else
    assign dout_val = !empty;
    assign err_long = 1'b0;
`endif

endmodule

// File: tb/tb_noc_pkt_fifo_vr.sv
// Directed bench for noc_pkt_fifo_vr. Inputs change 1 time unit after the
// rising edge; a negedge scoreboard tracks every accepted flit in order.
module tb_noc_pkt_fifo_vr;
    import noc_flit_pkg::*;

    localparam int DEPTH      = 8;
    localparam int LOG2_DEPTH = 3;

`ifdef PKT_FIFO_STORE_FWD_EN
    localparam logic SF = 1'b1;
`else
    localparam logic SF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [FLIT_W-1:0]   din_msg = '0;
    logic                din_val = 1'b0;
    logic                din_rdy;
    logic [FLIT_W-1:0]   dout_msg;
    logic                dout_val;
    logic                dout_rdy = 1'b0;
    logic [LOG2_DEPTH:0] occupancy;
    logic [LOG2_DEPTH:0] pkt_cnt;
    logic                err_long;

    int                  checks = 0;
    int                  errors = 0;
    int                  pops   = 0;
    int                  pops_before;
    logic [FLIT_W-1:0]   exp_q[$];
    logic [FLIT_W-1:0]   sb_exp;

    // Clock
    always #5 clk = ~clk;

    noc_pkt_fifo_vr #(.DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_msg   (din_msg),
        .din_val   (din_val),
        .din_rdy   (din_rdy),
        .dout_msg  (dout_msg),
        .dout_val  (dout_val),
        .dout_rdy  (dout_rdy),
        .occupancy (occupancy),
        .pkt_cnt   (pkt_cnt),
        .err_long  (err_long)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] plen, input logic [7:0] tag);
        return {14'h2A5, 8'd3, 8'd5, 4'h0, plen, 8'h11, 6'h0, tag};
    endfunction

    function automatic logic [63:0] pay(input logic [7:0] tag);
        return {32'hDA7A_0000, 24'h0, tag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [63:0] m);
        din_val = 1'b1;
        din_msg = m;
        step();
        din_val = 1'b0;
    endtask

    task automatic drain(input string tag);
        dout_rdy = 1'b1;
        din_val  = 1'b0;
        for (int i = 0; i < 40 && occupancy != '0; i++) step();
        check(tag, 64'(occupancy), 64'd0);
        dout_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        din_val  = 1'b0;
        dout_rdy = 1'b0;
        step();
        step();
        exp_q.delete();
        check("rst_din_rdy",   64'(din_rdy),   64'd0);
        check("rst_dout_val",  64'(dout_val),  64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
        check("rst_err_long",  64'(err_long),  64'd0);
        rst = 1'b0;
        #1;
        check("rst_din_rdy_after", 64'(din_rdy), 64'd1);
    endtask

    // Scoreboard: every popped flit must match the oldest accepted flit
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_val && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_data", dout_msg, sb_exp);
                end
                pops++;
            end
            if (din_val && din_rdy) exp_q.push_back(din_msg);
        end
    end

    initial begin
        do_reset();

        // 1: single-flit packet, immediate drain
        dout_rdy = 1'b1;
        push_flit(hdr(8'd0, 8'h01));
        check("t1_dout_val", 64'(dout_val),  64'd1);
        check("t1_pkt_cnt1", 64'(pkt_cnt),   64'd1);
        check("t1_occ1",     64'(occupancy), 64'd1);
        step();
        check("t1_pkt_cnt0", 64'(pkt_cnt),   64'd0);
        check("t1_dout_val0", 64'(dout_val), 64'd0);
        dout_rdy = 1'b0;

        // 2: four-flit packet buffered, then drained in four cycles
        push_flit(hdr(8'd3, 8'h02));
        push_flit(pay(8'h21));
        push_flit(pay(8'h22));
        check("t2_pkt_cnt_partial", 64'(pkt_cnt), 64'd0);
        push_flit(pay(8'h23));
        check("t2_occ4",    64'(occupancy), 64'd4);
        check("t2_pkt_cnt", 64'(pkt_cnt),   64'd1);
        dout_rdy = 1'b1;
        step(); step(); step();
        check("t2_occ1",      64'(occupancy), 64'd1);
        check("t2_pkt_cnt_3", 64'(pkt_cnt),   64'd1);
        step();
        check("t2_occ0",      64'(occupancy), 64'd0);
        check("t2_pkt_cnt_4", 64'(pkt_cnt),   64'd0);
        dout_rdy = 1'b0;

        // 3: fill to DEPTH, full refuses a flit even while popping
        for (int p = 0; p < 2; p++) begin
            push_flit(hdr(8'd3, 8'(8'h30 + p)));
            for (int f = 1; f <= 3; f++) push_flit(pay(8'(8'h30 + 4*p + f)));
        end
        check("t3_full_rdy", 64'(din_rdy),   64'd0);
        check("t3_occ8",     64'(occupancy), 64'd8);
        check("t3_pkt_cnt2", 64'(pkt_cnt),   64'd2);
        din_val  = 1'b1;
        din_msg  = hdr(8'd0, 8'hEE);
        dout_rdy = 1'b1;
        step();
        din_val  = 1'b0;
        dout_rdy = 1'b0;
        check("t3_rdy_after_pop", 64'(din_rdy),   64'd1);
        check("t3_occ7",          64'(occupancy), 64'd7);
        drain("t3_drain");
        check("t3_pkt_cnt0", 64'(pkt_cnt), 64'd0);

        // 4: partial packet is held in the store-and-forward build only
        push_flit(hdr(8'd3, 8'h04));
        push_flit(pay(8'h41));
        push_flit(pay(8'h42));
        check("t4_partial_val", 64'(dout_val), 64'(!SF));
        push_flit(pay(8'h43));
        check("t4_complete_val", 64'(dout_val), 64'd1);
        check("t4_pkt_cnt",      64'(pkt_cnt),  64'd1);
        drain("t4_drain");

        // 5: over-long packet streams cut-through, all ten flits delivered
        pops_before = pops;
        dout_rdy = 1'b1;
        push_flit(hdr(8'd9, 8'h05));
        check("t5_err_long", 64'(err_long), 64'(SF));
        check("t5_dout_val", 64'(dout_val), 64'd1);
        for (int f = 1; f <= 9; f++) push_flit(pay(8'(8'h50 + f)));
        drain("t5_drain");
        check("t5_delivered",   64'(pops - pops_before), 64'd10);
        check("t5_pkt_cnt0",    64'(pkt_cnt),            64'd0);
        check("t5_err_sticky",  64'(err_long),           64'(SF));

        // 6: reset mid-packet discards flits, next flit is a header again
        push_flit(hdr(8'd3, 8'h06));
        push_flit(pay(8'h61));
        check("t6_occ2", 64'(occupancy), 64'd2);
        do_reset();
        push_flit(hdr(8'd0, 8'h62));
        check("t6_hdr_after_rst", 64'(pkt_cnt), 64'd1);
        push_flit(hdr(8'd1, 8'h63));
        check("t6_pkt_cnt_hdr", 64'(pkt_cnt), 64'd1);
        push_flit(pay(8'h64));
        check("t6_pkt_cnt_pay", 64'(pkt_cnt), 64'd2);
        pops_before = pops;
        drain("t6_drain");
        check("t6_delivered", 64'(pops - pops_before), 64'd3);
        check("t6_pkt_cnt0",  64'(pkt_cnt),            64'd0);

        step();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
